// File: rtl/mac_rx_hdr_buffer.sv
// Ethernet II header capture stage behind the MAC RX FIFO.
// Latches the 14 header bytes, offers them on a header handshake, then passes payload bytes straight through.
module mac_rx_hdr_buffer #(
   parameter int HDR_BYTES = 14,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             hdr_valid,
   input  logic             hdr_ready,
   output logic [47:0]      hdr_dst_mac,
   output logic [47:0]      hdr_src_mac,
   output logic [15:0]      hdr_ethertype,
   output logic             hdr_has_payload,
   output logic             pl_valid,
   output logic [7:0]       pl_data,
   output logic             pl_last,
   input  logic             pl_ready,
   output logic             runt_err,
   output logic [CNT_W-1:0] runt_cnt
);

   typedef enum logic [1:0] {HDR, HDR_OUT, PAYLOAD} state_t;

   localparam logic [3:0] HDR_LAST = 4'(HDR_BYTES - 1);

   state_t           state_reg, state_next;
   logic [3:0]       hdr_idx_reg, hdr_idx_next;
   logic [7:0]       hdr_byte_reg [HDR_BYTES];
   logic             has_pl_reg, has_pl_next;
   logic             runt_err_reg, runt_err_next;
   logic [CNT_W-1:0] runt_cnt_reg, runt_cnt_next;
   logic             in_ready_c;
   logic             hdr_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= HDR;
         hdr_idx_reg  <= '0;
         has_pl_reg   <= 1'b0;
         runt_err_reg <= 1'b0;
         runt_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         hdr_idx_reg  <= hdr_idx_next;
         has_pl_reg   <= has_pl_next;
         runt_err_reg <= runt_err_next;
         runt_cnt_reg <= runt_cnt_next;
      end
   end

   // Header bytes are written in place, so fields keep their value until the next capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < HDR_BYTES; i++) hdr_byte_reg[i] <= '0;
      end else if (hdr_wr) begin
         for (int i = 0; i < HDR_BYTES; i++)
            if (hdr_idx_reg == 4'(i)) hdr_byte_reg[i] <= in_data;
      end
   end

   always_comb begin
      state_next    = state_reg;
      hdr_idx_next  = hdr_idx_reg;
      has_pl_next   = has_pl_reg;
      runt_err_next = 1'b0;
      runt_cnt_next = runt_cnt_reg;
      in_ready_c    = 1'b0;
      hdr_valid     = 1'b0;
      pl_valid      = 1'b0;
      pl_data       = '0;
      pl_last       = 1'b0;
      hdr_wr        = 1'b0;
      case (state_reg)
         HDR: begin
            in_ready_c = 1'b1;
            if (in_valid) begin
               hdr_wr = 1'b1;
               if (hdr_idx_reg == HDR_LAST) begin
                  state_next   = HDR_OUT;
                  has_pl_next  = !in_last;
                  hdr_idx_next = '0;
               end else if (in_last) begin
                  runt_err_next = 1'b1;
                  if (runt_cnt_reg != '1) runt_cnt_next = runt_cnt_reg + 1'b1;
                  hdr_idx_next  = '0;
               end else begin
                  hdr_idx_next = hdr_idx_reg + 4'd1;
               end
            end
         end
         HDR_OUT: begin
            hdr_valid = 1'b1;
            if (hdr_ready) state_next = has_pl_reg ? PAYLOAD : HDR;
         end
         PAYLOAD: begin
            pl_valid   = in_valid;
            pl_data    = in_data;
            pl_last    = in_last;
            in_ready_c = pl_ready;
            if (in_valid && pl_ready && in_last) state_next = HDR;
         end
         default: state_next = HDR;
      endcase
   end

   // Held low while rst_n is asserted so the FIFO sees no acceptance during reset.
   assign in_ready        = in_ready_c & rst_n;
   assign hdr_has_payload = has_pl_reg;
   assign runt_err        = runt_err_reg;
   assign runt_cnt        = runt_cnt_reg;
   assign hdr_ethertype   = {hdr_byte_reg[12], hdr_byte_reg[13]};

   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_mac
         assign hdr_dst_mac[47-8*gi -: 8] = hdr_byte_reg[gi];
         assign hdr_src_mac[47-8*gi -: 8] = hdr_byte_reg[6+gi];
      end
   endgenerate

endmodule

// File: tb/tb_mac_rx_hdr_buffer.sv
// Table-driven, scoreboarded bench for mac_rx_hdr_buffer.
module tb_mac_rx_hdr_buffer;

   localparam int CNT_W = 16;

   logic             clk, rst_n;
   logic             in_valid, in_last, in_ready;
   logic [7:0]       in_data;
   logic             hdr_valid, hdr_ready, hdr_has_payload;
   logic [47:0]      hdr_dst_mac, hdr_src_mac;
   logic [15:0]      hdr_ethertype;
   logic             pl_valid, pl_last, pl_ready;
   logic [7:0]       pl_data;
   logic             runt_err;
   logic [CNT_W-1:0] runt_cnt;

   mac_rx_hdr_buffer #(.HDR_BYTES(14), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
      .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac),
      .hdr_ethertype(hdr_ethertype), .hdr_has_payload(hdr_has_payload),
      .pl_valid(pl_valid), .pl_data(pl_data), .pl_last(pl_last), .pl_ready(pl_ready),
      .runt_err(runt_err), .runt_cnt(runt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int len;
      int hold;
      bit tog;
      bit exp_runt;
      bit exp_has_pl;
   } vec_t;

   typedef struct {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] et;
      logic        hp;
   } hdr_t;

   hdr_t       hdr_q[$];
   logic [8:0] pl_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int exp_runt_cnt = 0;
   int runt_sent = 0;
   int runt_seen = 0;
   int hdr_wait = 0;
   int hdr_hold = 0;
   bit pl_tog = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Consumer-side handshakes change just after the rising edge, like the driver.
   always @(posedge clk) begin
      #1;
      pl_ready  = pl_tog ? ~pl_ready : 1'b1;
      hdr_ready = (hdr_wait >= hdr_hold);
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (hdr_valid) begin
            check("hdr_in_ready_low", in_ready, 0);
            if (hdr_q.size() == 0) begin
               check("hdr_unexpected", hdr_valid, 0);
            end else begin
               check("hdr_dst", hdr_dst_mac, hdr_q[0].dst);
               check("hdr_src", hdr_src_mac, hdr_q[0].src);
               check("hdr_type", hdr_ethertype, hdr_q[0].et);
               check("hdr_has_pl", hdr_has_payload, hdr_q[0].hp);
               if (hdr_ready) begin
                  $display("HDR dst=%012h src=%012h type=%04h has_pl=%0b",
                           hdr_dst_mac, hdr_src_mac, hdr_ethertype, hdr_has_payload);
                  void'(hdr_q.pop_front());
               end
            end
            hdr_wait = hdr_ready ? 0 : hdr_wait + 1;
         end
         if (pl_valid) begin
            check("pl_ready_mirror", in_ready, pl_ready);
            if (pl_ready) begin
               if (pl_q.size() == 0) begin
                  check("pl_unexpected", pl_valid, 0);
               end else begin
                  check("pl_beat", {pl_last, pl_data}, pl_q.pop_front());
                  $display("PL  data=%02h last=%0b", pl_data, pl_last);
               end
            end
         end
         if (runt_err) begin
            runt_seen++;
            check("runt_cnt", runt_cnt, exp_runt_cnt);
            $display("RUNT cnt=%0d", runt_cnt);
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input int idx, input int len, input bit is_runt, input bit has_pl);
      logic [7:0] b[$];
      logic [7:0] fixed [17];
      hdr_t h;
      fixed = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC};
      for (int k = 0; k < len; k++)
         b.push_back((idx == 0 && k < 17) ? fixed[k] : 8'($urandom_range(0, 255)));
      if (!is_runt) begin
         for (int k = 0; k < 6; k++) begin
            h.dst[47-8*k -: 8] = b[k];
            h.src[47-8*k -: 8] = b[6+k];
         end
         h.et = {b[12], b[13]};
         h.hp = has_pl;
         hdr_q.push_back(h);
         for (int k = 14; k < len; k++) pl_q.push_back({k == len - 1, b[k]});
      end
      for (int k = 0; k < len; k++) begin
         send_byte(b[k], k == len - 1);
         if (k == 13) begin
            @(negedge clk);
            check("hdr_latency", hdr_valid, 1);
            if (idx == 0) begin
               check("t1_dst_const", hdr_dst_mac, 48'h010203040506);
               check("t1_type_const", hdr_ethertype, 16'h0800);
            end
            @(posedge clk); #1;
         end
      end
      if (is_runt) begin
         exp_runt_cnt++;
         runt_sent++;
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 500 && (hdr_q.size() != 0 || pl_q.size() != 0); c++) @(posedge clk);
      #1;
      check("drain_hdr_q", hdr_q.size(), 0);
      check("drain_pl_q", pl_q.size(), 0);
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{len: 17, hold: 0,  tog: 0, exp_runt: 0, exp_has_pl: 1};
      vecs[1] = '{len: 5,  hold: 0,  tog: 0, exp_runt: 1, exp_has_pl: 0};
      vecs[2] = '{len: 20, hold: 0,  tog: 0, exp_runt: 0, exp_has_pl: 1};
      vecs[3] = '{len: 14, hold: 0,  tog: 0, exp_runt: 0, exp_has_pl: 0};
      vecs[4] = '{len: 30, hold: 10, tog: 0, exp_runt: 0, exp_has_pl: 1};
      vecs[5] = '{len: 78, hold: 0,  tog: 1, exp_runt: 0, exp_has_pl: 1};
      vecs[6] = '{len: 1,  hold: 0,  tog: 0, exp_runt: 1, exp_has_pl: 0};
      vecs[7] = '{len: 13, hold: 0,  tog: 0, exp_runt: 1, exp_has_pl: 0};
      vecs[8] = '{len: 15, hold: 0,  tog: 0, exp_runt: 0, exp_has_pl: 1};

      rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      hdr_ready = 1'b1; pl_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hdr_valid", hdr_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_runt_cnt", runt_cnt, 0);
      check("rst_dst", hdr_dst_mac, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);
      check("idle_pl_valid", pl_valid, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         hdr_hold = vecs[i].hold;
         pl_tog   = vecs[i].tog;
         send_frame(i, vecs[i].len, vecs[i].exp_runt, vecs[i].exp_has_pl);
      end
      pl_tog = 1'b0;
      hdr_hold = 0;
      drain();
      check("runt_pulses", runt_seen, runt_sent);

      // Reset in the middle of a header: partial bytes are discarded.
      for (int k = 0; k < 7; k++) send_byte(8'($urandom_range(0, 255)), 1'b0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_hdr_valid", hdr_valid, 0);
      check("mid_rst_pl_valid", pl_valid, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_runt", {runt_err, runt_cnt}, 0);
      check("mid_rst_dst", hdr_dst_mac, 0);
      check("mid_rst_src", hdr_src_mac, 0);
      check("mid_rst_type", {hdr_ethertype, hdr_has_payload}, 0);
      exp_runt_cnt = 0;
      hdr_wait = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(99, 20, 1'b0, 1'b1);
      drain();
      check("post_rst_runt_cnt", runt_cnt, 0);
      check("runt_pulses_final", runt_seen, runt_sent);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
